// File: rtl/cpu_mem_arbiter_pkg.sv
// rtl/cpu_mem_arbiter_pkg.sv - shared encodings for the instruction/data memory-port arbiter
package cpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_INST = 2'd1,
    OWNER_DATA = 2'd2
  } owner_t;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - shares one sram-like port between fetch and data masters
// One outstanding transaction; data has priority until fetch has starved STARVE_LIMIT grants.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_inst_req,
  input  logic [1:0]        i_inst_size,
  input  logic [ADDR_W-1:0] i_inst_addr,
  output logic              o_inst_addr_ok,
  output logic              o_inst_data_ok,
  output logic [DATA_W-1:0] o_inst_rdata,
  input  logic              i_data_req,
  input  logic              i_data_wr,
  input  logic [1:0]        i_data_size,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [DATA_W-1:0] i_data_wdata,
  output logic              o_data_addr_ok,
  output logic              o_data_data_ok,
  output logic [DATA_W-1:0] o_data_rdata,
  output logic              o_mem_req,
  output logic              o_mem_wr,
  output logic [1:0]        o_mem_size,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_addr_ok,
  input  logic              i_mem_data_ok,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       r_state, w_next_state;
  owner_t           r_owner, w_next_owner;
  owner_t           r_lock,  w_next_lock;
  logic [CNT_W-1:0] r_starve_cnt, w_next_starve;
  owner_t           w_grant;
  logic             w_accept;
  logic             w_resp;

  always_comb begin
    w_grant = OWNER_NONE;
    case (r_state)
      ARB_IDLE: begin
        if (i_inst_req && (r_starve_cnt == CNT_W'(STARVE_LIMIT))) w_grant = OWNER_INST;
        else if (i_data_req)                                     w_grant = OWNER_DATA;
        else if (i_inst_req)                                     w_grant = OWNER_INST;
      end
      ARB_REQ: w_grant = r_lock;
      default: w_grant = OWNER_NONE;
    endcase
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_size  = 2'd0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (w_grant)
      OWNER_INST: begin
        o_mem_req  = i_inst_req;
        o_mem_size = i_inst_size;
        o_mem_addr = i_inst_addr;
      end
      OWNER_DATA: begin
        o_mem_req   = i_data_req;
        o_mem_wr    = i_data_wr;
        o_mem_size  = i_data_size;
        o_mem_addr  = i_data_addr;
        o_mem_wdata = i_data_wdata;
      end
      default: ;
    endcase
  end

  assign w_accept       = o_mem_req && i_mem_addr_ok;
  assign o_inst_addr_ok = w_accept && (w_grant == OWNER_INST);
  assign o_data_addr_ok = w_accept && (w_grant == OWNER_DATA);

  // Responses outside RESP are protocol violations and never reach a master.
  assign w_resp         = (r_state == ARB_RESP) && i_mem_data_ok;
  assign o_inst_data_ok = w_resp && (r_owner == OWNER_INST);
  assign o_data_data_ok = w_resp && (r_owner == OWNER_DATA);
  assign o_inst_rdata   = o_inst_data_ok ? i_mem_rdata : '0;
  assign o_data_rdata   = o_data_data_ok ? i_mem_rdata : '0;

  always_comb begin
    w_next_state  = r_state;
    w_next_owner  = r_owner;
    w_next_lock   = r_lock;
    w_next_starve = r_starve_cnt;
    case (r_state)
      ARB_IDLE, ARB_REQ: begin
        if (w_accept) begin
          w_next_state = ARB_RESP;
          w_next_owner = w_grant;
          w_next_lock  = OWNER_NONE;
          if (!i_inst_req || (w_grant == OWNER_INST)) w_next_starve = '0;
          else if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) w_next_starve = r_starve_cnt + 1'b1;
        end else if ((r_state == ARB_IDLE) && (w_grant != OWNER_NONE)) begin
          w_next_state = ARB_REQ;
          w_next_lock  = w_grant;
        end
      end
      ARB_RESP: begin
        if (i_mem_data_ok) begin
          w_next_state = ARB_IDLE;
          w_next_owner = OWNER_NONE;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWNER_NONE;
      r_lock       <= OWNER_NONE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_next_state;
      r_owner      <= w_next_owner;
      r_lock       <= w_next_lock;
      r_starve_cnt <= w_next_starve;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - directed self-checking bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_inst_req(inst_req), .i_inst_size(inst_size), .i_inst_addr(inst_addr),
    .o_inst_addr_ok(inst_addr_ok), .o_inst_data_ok(inst_data_ok), .o_inst_rdata(inst_rdata),
    .i_data_req(data_req), .i_data_wr(data_wr), .i_data_size(data_size),
    .i_data_addr(data_addr), .i_data_wdata(data_wdata),
    .o_data_addr_ok(data_addr_ok), .o_data_data_ok(data_data_ok), .o_data_rdata(data_rdata),
    .o_mem_req(mem_req), .o_mem_wr(mem_wr), .o_mem_size(mem_size), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_addr_ok(mem_addr_ok), .i_mem_data_ok(mem_data_ok),
    .i_mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_size = 2'd2; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    mem_addr_ok = 1;
    settle();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL reset_addr_ok got=%b exp=00", {inst_addr_ok, data_addr_ok}); end
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL reset_data_ok got=%b exp=00", {inst_data_ok, data_data_ok}); end
    mem_addr_ok = 0;
    step();
  endtask

  task automatic test_inst_only();
    inst_req = 1; inst_addr = 32'hBFC00000; mem_addr_ok = 1;
    settle();
    checks++; if ({mem_req, mem_wr, mem_addr} !== {1'b1, 1'b0, 32'hBFC00000}) begin errors++; $display("FAIL inst_mem_fields got=%b/%b/%h exp=1/0/bfc00000", mem_req, mem_wr, mem_addr); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL inst_addr_ok got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
    step();
    inst_req = 0; mem_addr_ok = 0;
    settle();
    checks++; if ({mem_req, inst_data_ok} !== 2'b00) begin errors++; $display("FAIL inst_wait got=%b exp=00", {mem_req, inst_data_ok}); end
    step();
    mem_data_ok = 1; mem_rdata = 32'h3C1D0001;
    settle();
    checks++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h3C1D0001}) begin errors++; $display("FAIL inst_data got=%b/%h exp=1/3c1d0001", inst_data_ok, inst_rdata); end
    checks++; if ({data_data_ok, data_addr_ok, data_rdata} !== 34'd0) begin errors++; $display("FAIL inst_data_side_quiet got=%b/%b/%h exp=0/0/0", data_data_ok, data_addr_ok, data_rdata); end
    step();
    mem_data_ok = 0;
  endtask

  task automatic test_priority();
    inst_req = 1; inst_addr = 32'hBFC00004;
    data_req = 1; data_wr = 1; data_addr = 32'h80000010; data_wdata = 32'h12345678;
    mem_addr_ok = 1;
    settle();
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin errors++; $display("FAIL prio_grant got=%b exp=10", {data_addr_ok, inst_addr_ok}); end
    checks++; if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h80000010, 32'h12345678}) begin errors++; $display("FAIL prio_mem_fields got=%b/%h/%h exp=1/80000010/12345678", mem_wr, mem_addr, mem_wdata); end
    step();
    data_req = 0; data_wr = 0;
    settle();
    checks++; if ({mem_req, inst_addr_ok} !== 2'b00) begin errors++; $display("FAIL prio_resp_block got=%b exp=00", {mem_req, inst_addr_ok}); end
    mem_data_ok = 1;
    settle();
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin errors++; $display("FAIL prio_store_done got=%b exp=10", {data_data_ok, inst_data_ok}); end
    step();
    mem_data_ok = 0;
    settle();
    checks++; if ({inst_addr_ok, mem_addr} !== {1'b1, 32'hBFC00004}) begin errors++; $display("FAIL prio_inst_next got=%b/%h exp=1/bfc00004", inst_addr_ok, mem_addr); end
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    step();
    mem_data_ok = 0;
  endtask

  task automatic test_starvation();
    logic exp_inst;
    inst_req = 1; inst_addr = 32'hBFC00100;
    data_req = 1; data_wr = 0; data_addr = 32'h80000200;
    for (int k = 0; k < 6; k++) begin
      exp_inst = (k == 4);
      mem_addr_ok = 1; mem_data_ok = 0;
      settle();
      checks++; if ({inst_addr_ok, data_addr_ok} !== {exp_inst, ~exp_inst}) begin errors++; $display("FAIL starve_grant%0d got=%b exp=%b", k, {inst_addr_ok, data_addr_ok}, {exp_inst, ~exp_inst}); end
      step();
      mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hA0 + k;
      settle();
      checks++; if ({inst_data_ok, data_data_ok} !== {exp_inst, ~exp_inst}) begin errors++; $display("FAIL starve_resp%0d got=%b exp=%b", k, {inst_data_ok, data_data_ok}, {exp_inst, ~exp_inst}); end
      step();
    end
    inst_req = 0; data_req = 0; mem_data_ok = 0;
    step();
  endtask

  task automatic test_req_hold();
    inst_req = 1; inst_addr = 32'h00001000;
    settle();
    checks++; if ({mem_req, mem_addr, inst_addr_ok} !== {1'b1, 32'h00001000, 1'b0}) begin errors++; $display("FAIL hold_issue got=%b/%h/%b exp=1/00001000/0", mem_req, mem_addr, inst_addr_ok); end
    step();
    data_req = 1; data_wr = 1; data_addr = 32'h00002000; data_wdata = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if ({mem_addr, mem_wr, data_addr_ok, inst_addr_ok} !== {32'h00001000, 3'b000}) begin errors++; $display("FAIL hold_frozen%0d got=%h/%b/%b/%b exp=00001000/0/0/0", k, mem_addr, mem_wr, data_addr_ok, inst_addr_ok); end
      step();
    end
    mem_addr_ok = 1;
    settle();
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL hold_accept got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    settle();
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL hold_inst_resp got=%b exp=10", {inst_data_ok, data_data_ok}); end
    step();
    mem_data_ok = 0; mem_addr_ok = 1;
    settle();
    checks++; if ({data_addr_ok, mem_addr, mem_wdata} !== {1'b1, 32'h00002000, 32'hCAFEF00D}) begin errors++; $display("FAIL hold_data_after got=%b/%h/%h exp=1/00002000/cafef00d", data_addr_ok, mem_addr, mem_wdata); end
    step();
    data_req = 0; data_wr = 0; mem_addr_ok = 0; mem_data_ok = 1;
    step();
    mem_data_ok = 0;
  endtask

  task automatic test_reset_mid();
    data_req = 1; data_addr = 32'h80000040; mem_addr_ok = 1;
    settle();
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL rmid_accept got=%b exp=1", data_addr_ok); end
    step();
    data_req = 0; mem_addr_ok = 0;
    reset = 1;
    step();
    reset = 0; mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
    settle();
    checks++; if ({inst_data_ok, data_data_ok, mem_req, data_rdata} !== 35'd0) begin errors++; $display("FAIL rmid_discard got=%b/%b/%b/%h exp=0/0/0/0", inst_data_ok, data_data_ok, mem_req, data_rdata); end
    step();
    mem_data_ok = 0; inst_req = 1; inst_addr = 32'hBFC00200; mem_addr_ok = 1;
    settle();
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL rmid_idle got=%b exp=1", inst_addr_ok); end
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    step();
    mem_data_ok = 0;
  endtask

  task automatic test_spurious();
    mem_data_ok = 1; mem_rdata = 32'h55AA55AA;
    settle();
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL spur_idle got=%b exp=00", {inst_data_ok, data_data_ok}); end
    step();
    mem_data_ok = 0; inst_req = 1; inst_addr = 32'hBFC00300;
    step();
    mem_data_ok = 1;
    settle();
    checks++; if ({inst_data_ok, data_data_ok, inst_addr_ok} !== 3'b000) begin errors++; $display("FAIL spur_req got=%b exp=000", {inst_data_ok, data_data_ok, inst_addr_ok}); end
    step();
    mem_data_ok = 0; mem_addr_ok = 1;
    settle();
    checks++; if ({inst_addr_ok, mem_addr} !== {1'b1, 32'hBFC00300}) begin errors++; $display("FAIL spur_recover got=%b/%h exp=1/bfc00300", inst_addr_ok, mem_addr); end
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    step();
    mem_data_ok = 0;
  endtask

  initial begin
    test_reset();
    test_inst_only();
    test_priority();
    test_starvation();
    test_req_hold();
    test_reset_mid();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
